// File: rtl/pes_crc16_check.sv
// rtl/pes_crc16_check.sv - receive-side CRC-16 (0x8005) frame checker that strips the two trailing CRC bytes
// Optional error-frame counter enabled by defining PES_CRC16_ERRCNT_EN.
module pes_crc16_check #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             din_valid,
   input  logic [7:0]       din,
   input  logic             d_last,
   output logic [7:0]       dout,
   output logic             dout_valid,
   output logic             busy,
   output logic             done,
   output logic             crc_ok,
   output logic             crc_err,
   output logic             len_err,
   output logic [CNT_W-1:0] byte_cnt,
   output logic [7:0]       err_cnt
);

   typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

   state_t      state;
   state_t      state_next;
   logic [15:0] crc;
   logic [7:0]  hold0;
   logic [7:0]  hold1;
   logic [1:0]  hold_cnt;
   logic        runt;
   logic        accept;
   logic        take_last;
   logic        finish;
   logic        frame_bad;

   function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      logic        fb;
      r = c;
      for (int i = 7; i >= 0; i--) begin
         fb = r[15] ^ d[i];
         r  = {r[14:0], 1'b0};
         if (fb)
            r = r ^ 16'h8005;
      end
      return r;
   endfunction

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      take_last  = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (load)
               state_next = RECV;
         end
         RECV: begin
            if (load) begin
               state_next = RECV;
            end else if (din_valid) begin
               accept = 1'b1;
               if (d_last) begin
                  take_last  = 1'b1;
                  state_next = CHECK;
               end
            end
         end
         CHECK: begin
            if (load) begin
               state_next = RECV;
            end else begin
               finish     = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy      = (state != IDLE);
   assign frame_bad = runt || (crc != 16'h0000);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         crc        <= 16'h0000;
         hold0      <= 8'h00;
         hold1      <= 8'h00;
         hold_cnt   <= 2'd0;
         runt       <= 1'b0;
         dout       <= 8'h00;
         dout_valid <= 1'b0;
         done       <= 1'b0;
         crc_ok     <= 1'b0;
         crc_err    <= 1'b0;
         len_err    <= 1'b0;
         byte_cnt   <= '0;
      end else begin
         state      <= state_next;
         dout_valid <= 1'b0;
         done       <= 1'b0;
         if (load) begin
            crc      <= 16'h0000;
            hold0    <= 8'h00;
            hold1    <= 8'h00;
            hold_cnt <= 2'd0;
            runt     <= 1'b0;
            crc_ok   <= 1'b0;
            crc_err  <= 1'b0;
            len_err  <= 1'b0;
            byte_cnt <= '0;
         end else begin
            if (accept) begin
               crc <= crc16_byte(crc, din);
               // Two-deep delay line: a byte only leaves once two newer bytes exist behind it,
               // so the final two bytes (the CRC) are never emitted.
               case (hold_cnt)
                  2'd0: begin
                     hold0    <= din;
                     hold_cnt <= 2'd1;
                  end
                  2'd1: begin
                     hold1    <= din;
                     hold_cnt <= 2'd2;
                  end
                  default: begin
                     dout       <= hold0;
                     dout_valid <= 1'b1;
                     hold0      <= hold1;
                     hold1      <= din;
                     if (byte_cnt != {CNT_W{1'b1}})
                        byte_cnt <= byte_cnt + 1'b1;
                  end
               endcase
               if (take_last) begin
                  hold_cnt <= 2'd0;
                  runt     <= (byte_cnt == '0) && (hold_cnt != 2'd2);
               end
            end
            if (finish) begin
               done    <= 1'b1;
               crc_ok  <= !frame_bad;
               crc_err <= frame_bad;
               len_err <= runt;
            end
         end
      end
   end

`ifdef PES_CRC16_ERRCNT_EN
   logic [7:0] err_cnt_q;

   always_ff @(posedge clk) begin
      if (rst)
         err_cnt_q <= 8'h00;
      else if (finish && frame_bad && (err_cnt_q != 8'hFF))
         err_cnt_q <= err_cnt_q + 8'h01;
   end

   assign err_cnt = err_cnt_q;
`else
   assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_pes_crc16_check.sv
// tb/tb_pes_crc16_check.sv - directed self-checking bench for pes_crc16_check
module tb_pes_crc16_check;

   logic        clk;
   logic        rst;
   logic        load;
   logic        din_valid;
   logic [7:0]  din;
   logic        d_last;
   logic [7:0]  dout;
   logic        dout_valid;
   logic        busy;
   logic        done;
   logic        crc_ok;
   logic        crc_err;
   logic        len_err;
   logic [15:0] byte_cnt;
   logic [7:0]  err_cnt;

   int          vectors;
   int          miscompares;
   int          done_cnt;
   int          exp_err;
   logic [7:0]  out_q [$];
   logic [7:0]  fr [0:10];

   pes_crc16_check #(.CNT_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .din_valid (din_valid),
      .din       (din),
      .d_last    (d_last),
      .dout      (dout),
      .dout_valid(dout_valid),
      .busy      (busy),
      .done      (done),
      .crc_ok    (crc_ok),
      .crc_err   (crc_err),
      .len_err   (len_err),
      .byte_cnt  (byte_cnt),
      .err_cnt   (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      #2;
      if (dout_valid)
         out_q.push_back(dout);
      if (done)
         done_cnt++;
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_good();
      fr[0] = 8'h31; fr[1] = 8'h32; fr[2] = 8'h33; fr[3] = 8'h34;
      fr[4] = 8'h35; fr[5] = 8'h36; fr[6] = 8'h37; fr[7] = 8'h38;
      fr[8] = 8'h39; fr[9] = 8'hFE; fr[10] = 8'hE8;
   endtask

   // Pulses load, then drives fr[0..n-1]; returns at the negedge after the last byte.
   task automatic send_frame(input int n, input bit with_last);
      load = 1'b1;
      tick();
      load = 1'b0;
      out_q.delete();
      for (int i = 0; i < n; i++) begin
         din_valid = 1'b1;
         din       = fr[i];
         d_last    = with_last && (i == n - 1);
         tick();
      end
      din_valid = 1'b0;
      d_last    = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) tick();
      vectors++; if (dout !== 8'h00) begin miscompares++; $display("FAIL reset_dout: got %h want 00", dout); end
      vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL reset_dout_valid: got %b want 0", dout_valid); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
      vectors++; if ({crc_ok, crc_err, len_err} !== 3'b000) begin miscompares++; $display("FAIL reset_status: got %b want 000", {crc_ok, crc_err, len_err}); end
      vectors++; if (byte_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_byte_cnt: got %0d want 0", byte_cnt); end
      vectors++; if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_good();
      set_good();
      load = 1'b1;
      tick();
      load = 1'b0;
      out_q.delete();
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL good_busy_rise: got %b want 1", busy); end
      for (int i = 0; i < 11; i++) begin
         din_valid = 1'b1;
         din       = fr[i];
         d_last    = (i == 10);
         tick();
         if (i == 1) begin
            vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL good_early_dout: got %b want 0", dout_valid); end
         end
         if (i == 2) begin
            vectors++; if ({dout_valid, dout} !== {1'b1, 8'h31}) begin miscompares++; $display("FAIL good_first_dout: got %b/%h want 1/31", dout_valid, dout); end
         end
      end
      din_valid = 1'b0;
      d_last    = 1'b0;
      vectors++; if ({busy, done} !== 2'b10) begin miscompares++; $display("FAIL good_check_cycle: got busy/done %b want 10", {busy, done}); end
      tick();
      vectors++; if ({done, crc_ok, crc_err, len_err} !== 4'b1100) begin miscompares++; $display("FAIL good_result: got %b want 1100", {done, crc_ok, crc_err, len_err}); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL good_busy_fall: got %b want 0", busy); end
      vectors++; if (byte_cnt !== 16'd9) begin miscompares++; $display("FAIL good_byte_cnt: got %0d want 9", byte_cnt); end
      vectors++; if (out_q.size() !== 9) begin miscompares++; $display("FAIL good_out_count: got %0d want 9", out_q.size()); end
      for (int i = 0; i < 9 && i < out_q.size(); i++) begin
         vectors++; if (out_q[i] !== 8'h31 + 8'(i)) begin miscompares++; $display("FAIL good_out_byte%0d: got %h want %h", i, out_q[i], 8'h31 + 8'(i)); end
      end
      tick();
      vectors++; if ({done, crc_ok} !== 2'b01) begin miscompares++; $display("FAIL good_hold: got done/crc_ok %b want 01", {done, crc_ok}); end
   endtask

   task automatic test_corrupt();
      set_good();
      fr[10] = 8'hE9;
      send_frame(11, 1'b1);
      tick();
`ifdef PES_CRC16_ERRCNT_EN
      exp_err++;
`endif
      vectors++; if ({done, crc_ok, crc_err, len_err} !== 4'b1010) begin miscompares++; $display("FAIL corrupt_result: got %b want 1010", {done, crc_ok, crc_err, len_err}); end
      vectors++; if (out_q.size() !== 9) begin miscompares++; $display("FAIL corrupt_out_count: got %0d want 9", out_q.size()); end
      vectors++; if (err_cnt !== 8'(exp_err)) begin miscompares++; $display("FAIL corrupt_err_cnt: got %0d want %0d", err_cnt, exp_err); end
      set_good();
   endtask

   task automatic test_runt();
      fr[0] = 8'hAB;
      fr[1] = 8'hCD;
      send_frame(2, 1'b1);
      tick();
`ifdef PES_CRC16_ERRCNT_EN
      exp_err++;
`endif
      vectors++; if ({done, crc_ok, crc_err, len_err} !== 4'b1011) begin miscompares++; $display("FAIL runt_result: got %b want 1011", {done, crc_ok, crc_err, len_err}); end
      vectors++; if (out_q.size() !== 0) begin miscompares++; $display("FAIL runt_out_count: got %0d want 0", out_q.size()); end
      vectors++; if (byte_cnt !== 16'd0) begin miscompares++; $display("FAIL runt_byte_cnt: got %0d want 0", byte_cnt); end
      vectors++; if (err_cnt !== 8'(exp_err)) begin miscompares++; $display("FAIL runt_err_cnt: got %0d want %0d", err_cnt, exp_err); end
      set_good();
   endtask

   task automatic test_abort();
      int dc;
      set_good();
      dc = done_cnt;
      send_frame(5, 1'b0);
      send_frame(11, 1'b1);
      tick();
      vectors++; if (done_cnt !== dc + 1) begin miscompares++; $display("FAIL abort_done_count: got %0d want %0d", done_cnt - dc, 1); end
      vectors++; if ({done, crc_ok, crc_err} !== 3'b110) begin miscompares++; $display("FAIL abort_result: got %b want 110", {done, crc_ok, crc_err}); end
      vectors++; if (byte_cnt !== 16'd9) begin miscompares++; $display("FAIL abort_byte_cnt: got %0d want 9", byte_cnt); end
      vectors++; if (out_q.size() !== 9) begin miscompares++; $display("FAIL abort_out_count: got %0d want 9", out_q.size()); end
      if (out_q.size() > 0) begin
         vectors++; if (out_q[0] !== 8'h31) begin miscompares++; $display("FAIL abort_first_out: got %h want 31", out_q[0]); end
      end
   endtask

   task automatic test_rst_midframe();
      int dc;
      set_good();
      send_frame(4, 1'b0);
      vectors++; if (byte_cnt !== 16'd2) begin miscompares++; $display("FAIL rst_pre_byte_cnt: got %0d want 2", byte_cnt); end
      rst = 1'b1;
      tick();
      exp_err = 0;
      vectors++; if ({busy, done, dout_valid, crc_ok, crc_err, len_err} !== 6'b000000) begin miscompares++; $display("FAIL rst_flags: got %b want 000000", {busy, done, dout_valid, crc_ok, crc_err, len_err}); end
      vectors++; if ({dout, byte_cnt, err_cnt} !== 32'h0) begin miscompares++; $display("FAIL rst_values: got %h/%0d/%0d want 00/0/0", dout, byte_cnt, err_cnt); end
      rst = 1'b0;
      dc = done_cnt;
      out_q.delete();
      din_valid = 1'b1;
      d_last    = 1'b1;
      din       = 8'h55;
      repeat (4) tick();
      din_valid = 1'b0;
      d_last    = 1'b0;
      tick();
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_stray_busy: got %b want 0", busy); end
      vectors++; if (out_q.size() !== 0) begin miscompares++; $display("FAIL idle_stray_out: got %0d want 0", out_q.size()); end
      vectors++; if (done_cnt !== dc) begin miscompares++; $display("FAIL idle_stray_done: got %0d want 0", done_cnt - dc); end
   endtask

   task automatic test_back_to_back();
      int dc;
      set_good();
      dc = done_cnt;
      send_frame(11, 1'b1);
      tick();
      vectors++; if ({done, crc_ok} !== 2'b11) begin miscompares++; $display("FAIL b2b_first: got done/crc_ok %b want 11", {done, crc_ok}); end
      send_frame(11, 1'b1);
      tick();
      vectors++; if ({done, crc_ok, crc_err} !== 3'b110) begin miscompares++; $display("FAIL b2b_second: got %b want 110", {done, crc_ok, crc_err}); end
      vectors++; if (done_cnt !== dc + 2) begin miscompares++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt - dc); end
      vectors++; if (out_q.size() !== 9) begin miscompares++; $display("FAIL b2b_out_count: got %0d want 9", out_q.size()); end
      tick();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      done_cnt    = 0;
      exp_err     = 0;
      rst         = 1'b1;
      load        = 1'b0;
      din_valid   = 1'b0;
      din         = 8'h00;
      d_last      = 1'b0;
      set_good();
      test_reset();
      test_good();
      test_corrupt();
      test_runt();
      test_abort();
      test_rst_midframe();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
